interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Arbitrates the sticky interrupt flags of up to eight peripherals (counter_timer top/match0/match1 flags, UART, GPIO) into a single CPU interrupt request with a 3-bit vector.
- Runs an irq/ack/reti handshake and pulses the winning source's flag-clear line on acknowledge.
- Sits on the 8-bit I/O bus beside counter_timer, with the same din/address/w_en/r_en/dout register access.

Parameters:
- INTERRUPT_CONTROLLER_ADDRESS, 8'h00, base I/O address. Registers occupy base+0 to base+4.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- din  input  8  I/O write data
- address  input  8  I/O address
- w_en  input  1  I/O write strobe
- r_en  input  1  I/O read strobe
- dout  output  8  I/O read data, registered
- src_flag  input  8  level/sticky interrupt flags; bit i = source i
- src_clr  output  8  one-cycle clear pulses to source flags (drive *_flag_clr)
- irq  output  1  interrupt request to CPU
- irq_vector  output  3  index of the requested/in-service source
- irq_ack  input  1  CPU accepts the request (one-cycle pulse)
- reti  input  1  CPU finished the service routine (one-cycle pulse)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset values: irq=0, irq_vector=0, src_clr=0, dout=0, ENABLE=0, CONTROL=0, ACK_COUNT=0, state=IDLE. Reset mid-operation abandons any request or service with no clear pulse.
- Register map:
  - base+0 ENABLE: rw, per-source mask.
  - base+1 PENDING: read = src_flag & ENABLE. Writing 1 to bit i pulses src_clr[i] on the next cycle; writing 0 has no effect.
  - base+2 STATUS: read-only. bit7 = in service, bit6 = irq, bits2:0 = irq_vector, other bits 0.
  - base+3 CONTROL: rw. bit0 = global enable; other bits are stored and have no function.
  - base+4 ACK_COUNT: 8-bit count of acknowledges, saturating at 255. Any write clears it to 0.
- Reads: dout updates one cycle after r_en. Unmapped addresses drive dout=0.
- Arbitration: pend = src_flag & ENABLE. Winner = lowest set index (fixed priority, bit0 highest).
- State machine:
  - IDLE: if CONTROL[0] and pend!=0, latch winner into irq_vector, set irq=1, go REQ. irq rises the cycle after the flag is visible on src_flag.
  - REQ: on irq_ack, irq=0, src_clr[irq_vector]=1 for exactly one cycle, ACK_COUNT increments, go SERVICE.
    - Otherwise, if pend[irq_vector]==0 or CONTROL[0]==0, withdraw: irq=0, go IDLE.
    - The vector never changes while in REQ, even if a higher-priority source arrives.
  - SERVICE: irq stays 0 and new requests are held off. On reti, go IDLE; re-arbitration happens there the following cycle, so there is at least one cycle of irq=0 between services.
- Handshake rules:
  - irq_ack outside REQ and reti outside SERVICE are ignored.
  - If irq_ack arrives in the same cycle as a withdrawal condition, the ack wins.
- Simultaneous clears: src_clr is the OR of the ack-generated pulse and the PENDING write-1 pulses.
- Simultaneous ACK_COUNT events: if an increment and a write-clear fall in the same cycle, the write wins (result 0).

Decomposition:
- Package interrupt_controller_pkg holds:
  - register offset constants: ENABLE=0, PENDING=1, STATUS=2, CONTROL=3, ACK_COUNT=4;
  - the state encoding IDLE/REQ/SERVICE;
  - STATUS bit positions.
- One sub-module is natural: priority_encoder8, purely combinational. Input 8-bit request; outputs 3-bit index and a valid bit.

Test Plan:
- ENABLE=8'h06, CONTROL=1, assert src_flag=8'h06 -> next cycle irq=1, irq_vector=1. irq_ack -> src_clr=8'h02 for one cycle, STATUS=8'h81, ACK_COUNT=1.
- In SERVICE with src_flag[0] newly set and enabled -> irq stays 0 until reti. reti -> irq=1 with vector 0 two cycles after reti.
- In REQ on vector 3, write ENABLE=0 -> irq=0 the next cycle, state IDLE, no src_clr pulse. Repeat with irq_ack in the same cycle as the ENABLE write -> ack wins, src_clr=8'h08.
- Write PENDING=8'h30 while an ack clears source 2 in the same cycle -> src_clr=8'h34 for one cycle.
- 256 ack/reti cycles -> ACK_COUNT reads 255. A write to base+4 -> reads 0. A read of base+7 -> dout=0.
- Assert rst while in REQ -> next cycle irq=0, irq_vector=0, ENABLE=0, CONTROL=0; later irq_ack pulses are ignored.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// handshake state encoding and STATUS bit positions.
package interrupt_controller_pkg;

    localparam logic [7:0] OFF_ENABLE    = 8'd0;
    localparam logic [7:0] OFF_PENDING   = 8'd1;
    localparam logic [7:0] OFF_STATUS    = 8'd2;
    localparam logic [7:0] OFF_CONTROL   = 8'd3;
    localparam logic [7:0] OFF_ACK_COUNT = 8'd4;

    localparam int STATUS_IN_SERVICE_BIT = 7;
    localparam int STATUS_IRQ_BIT        = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/interrupt_controller_priority_encoder8.sv
// Fixed-priority encoder: reports the lowest set request bit (bit0 wins).
module priority_encoder8 (
    input  logic [7:0] request,
    output logic [2:0] index,
    output logic       valid
);

    always_comb begin
        index = 3'd0;
        valid = |request;
        // Scan downward so the lowest set bit is the last to assign.
        for (int i = 7; i >= 0; i--) begin
            if (request[i]) begin
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Eight-source interrupt controller with irq/ack/reti handshake and an
// 8-bit I/O register window (ENABLE, PENDING, STATUS, CONTROL, ACK_COUNT).
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [7:0] INTERRUPT_CONTROLLER_ADDRESS = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic [7:0] src_flag,
    output logic [7:0] src_clr,
    output logic       irq,
    output logic [2:0] irq_vector,
    input  logic       irq_ack,
    input  logic       reti
);

    state_t     state_reg, state_next;
    logic       irq_reg, irq_next;
    logic [2:0] irq_vector_reg, irq_vector_next;
    logic [7:0] enable_reg, control_reg, ack_count_reg;
    logic [7:0] src_clr_reg, dout_reg;

    logic [7:0] offset;
    logic [7:0] pend;
    logic [2:0] win_index;
    logic       win_valid;
    logic       ack_take;
    logic [7:0] ack_clr;
    logic [7:0] read_data;
    logic       wr_enable, wr_pending, wr_control, wr_ack_count;

    assign offset       = address - INTERRUPT_CONTROLLER_ADDRESS;
    assign wr_enable    = w_en && (offset == OFF_ENABLE);
    assign wr_pending   = w_en && (offset == OFF_PENDING);
    assign wr_control   = w_en && (offset == OFF_CONTROL);
    assign wr_ack_count = w_en && (offset == OFF_ACK_COUNT);

    assign pend = src_flag & enable_reg;

    priority_encoder8 u_prio (
        .request (pend),
        .index   (win_index),
        .valid   (win_valid)
    );

    // Ack-generated clear pulse targets only the source being acknowledged.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ack_clr
            assign ack_clr[gi] = ack_take && (irq_vector_reg == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        irq_next        = irq_reg;
        irq_vector_next = irq_vector_reg;
        ack_take        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (control_reg[0] && win_valid) begin
                    irq_vector_next = win_index;
                    irq_next        = 1'b1;
                    state_next      = REQ;
                end
            end
            REQ: begin
                // An ack beats a simultaneous withdrawal condition.
                if (irq_ack) begin
                    ack_take   = 1'b1;
                    irq_next   = 1'b0;
                    state_next = SERVICE;
                end else if (!pend[irq_vector_reg] || !control_reg[0]) begin
                    irq_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                irq_next = 1'b0;
                if (reti) begin
                    state_next = IDLE;
                end
            end
            default: begin
                irq_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        read_data = 8'h00;
        case (offset)
            OFF_ENABLE:    read_data = enable_reg;
            OFF_PENDING:   read_data = pend;
            OFF_STATUS: begin
                read_data[STATUS_IN_SERVICE_BIT] = (state_reg == SERVICE);
                read_data[STATUS_IRQ_BIT]        = irq_reg;
                read_data[2:0]                   = irq_vector_reg;
            end
            OFF_CONTROL:   read_data = control_reg;
            OFF_ACK_COUNT: read_data = ack_count_reg;
            default:       read_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            irq_reg        <= 1'b0;
            irq_vector_reg <= 3'd0;
            enable_reg     <= 8'h00;
            control_reg    <= 8'h00;
            ack_count_reg  <= 8'h00;
            src_clr_reg    <= 8'h00;
            dout_reg       <= 8'h00;
        end else begin
            state_reg      <= state_next;
            irq_reg        <= irq_next;
            irq_vector_reg <= irq_vector_next;
            src_clr_reg    <= (wr_pending ? din : 8'h00) | ack_clr;
            if (wr_enable) begin
                enable_reg <= din;
            end
            if (wr_control) begin
                control_reg <= din;
            end
            // A write-clear takes precedence over a same-cycle increment.
            if (wr_ack_count) begin
                ack_count_reg <= 8'h00;
            end else if (ack_take && (ack_count_reg != 8'hFF)) begin
                ack_count_reg <= ack_count_reg + 8'd1;
            end
            if (r_en) begin
                dout_reg <= read_data;
            end
        end
    end

    assign dout       = dout_reg;
    assign src_clr    = src_clr_reg;
    assign irq        = irq_reg;
    assign irq_vector = irq_vector_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller: handshake, priority,
// withdrawal, clear merging, ACK_COUNT saturation and reset abandonment.
module tb_interrupt_controller;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic [7:0] src_flag;
    logic [7:0] src_clr;
    logic       irq;
    logic [2:0] irq_vector;
    logic       irq_ack;
    logic       reti;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd;

    interrupt_controller #(.INTERRUPT_CONTROLLER_ADDRESS(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .address    (address),
        .w_en       (w_en),
        .r_en       (r_en),
        .dout       (dout),
        .src_flag   (src_flag),
        .src_clr    (src_clr),
        .irq        (irq),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .reti       (reti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a;
        din     = d;
        w_en    = 1'b1;
        step();
        w_en    = 1'b0;
    endtask

    task automatic rdreg(input logic [7:0] a, output logic [7:0] d);
        address = a;
        r_en    = 1'b1;
        step();
        r_en    = 1'b0;
        d       = dout;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_reti();
        reti = 1'b1;
        step();
        reti = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
        src_flag = 8'h00; irq_ack = 1'b0; reti = 1'b0;
        step();
        step();
        check("rst_irq", {7'd0, irq}, 8'h00);
        check("rst_vec", {5'd0, irq_vector}, 8'h00);
        check("rst_clr", src_clr, 8'h00);
        check("rst_dout", dout, 8'h00);
        rst = 1'b0;

        // Basic request on source 1 of flags 0x06
        wr(8'h00, 8'h06);
        wr(8'h03, 8'h01);
        src_flag = 8'h06;
        step();
        check("req_irq", {7'd0, irq}, 8'h01);
        check("req_vec", {5'd0, irq_vector}, 8'h01);
        pulse_ack();
        check("ack_clr", src_clr, 8'h02);
        check("ack_irq", {7'd0, irq}, 8'h00);
        src_flag = 8'h04;
        step();
        check("ack_clr_once", src_clr, 8'h00);
        rdreg(8'h02, rd);
        check("status_svc", rd, 8'h81);
        rdreg(8'h04, rd);
        check("ackcnt_1", rd, 8'h01);

        // Higher-priority source during SERVICE is held off until reti
        wr(8'h00, 8'h07);
        src_flag = 8'h05;
        step();
        step();
        check("svc_hold", {7'd0, irq}, 8'h00);
        pulse_reti();
        check("reti_gap", {7'd0, irq}, 8'h00);
        step();
        check("rearb_irq", {7'd0, irq}, 8'h01);
        check("rearb_vec", {5'd0, irq_vector}, 8'h00);
        pulse_ack();
        check("ack0_clr", src_clr, 8'h01);
        src_flag = 8'h00;
        pulse_reti();

        // Vector 3 request, vector held, then withdrawn by ENABLE=0
        wr(8'h00, 8'h08);
        src_flag = 8'h08;
        step();
        check("v3_irq", {7'd0, irq}, 8'h01);
        check("v3_vec", {5'd0, irq_vector}, 8'h03);
        src_flag = 8'h09;
        wr(8'h00, 8'h09);
        step();
        check("v3_hold_vec", {5'd0, irq_vector}, 8'h03);
        check("v3_hold_irq", {7'd0, irq}, 8'h01);
        wr(8'h00, 8'h00);
        check("wd_clr0", src_clr, 8'h00);
        step();
        check("wd_irq", {7'd0, irq}, 8'h00);
        check("wd_clr1", src_clr, 8'h00);
        rdreg(8'h02, rd);
        check("wd_status", rd, 8'h03);

        // Ack in the same cycle as the ENABLE=0 write: ack wins
        wr(8'h00, 8'h08);
        step();
        check("v3b_irq", {7'd0, irq}, 8'h01);
        address = 8'h00; din = 8'h00; w_en = 1'b1; irq_ack = 1'b1;
        step();
        w_en = 1'b0; irq_ack = 1'b0;
        check("ackwin_clr", src_clr, 8'h08);
        check("ackwin_irq", {7'd0, irq}, 8'h00);
        rdreg(8'h02, rd);
        check("ackwin_status", rd, 8'h83);
        src_flag = 8'h00;
        pulse_reti();

        // Ack in the same cycle the flag drops: ack still wins
        wr(8'h00, 8'h08);
        src_flag = 8'h08;
        step();
        check("v3c_irq", {7'd0, irq}, 8'h01);
        src_flag = 8'h00; irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("ackdrop_clr", src_clr, 8'h08);
        rdreg(8'h02, rd);
        check("ackdrop_status", rd, 8'h83);
        pulse_reti();

        // PENDING write-1 merged with ack clear of source 2
        wr(8'h00, 8'h04);
        src_flag = 8'h04;
        step();
        check("v2_vec", {5'd0, irq_vector}, 8'h02);
        address = 8'h01; din = 8'h30; w_en = 1'b1; irq_ack = 1'b1;
        step();
        w_en = 1'b0; irq_ack = 1'b0;
        check("merge_clr", src_clr, 8'h34);
        src_flag = 8'h00;
        step();
        check("merge_clr_once", src_clr, 8'h00);
        pulse_reti();
        wr(8'h01, 8'h81);
        check("pend_wr_clr", src_clr, 8'h81);
        rdreg(8'h04, rd);
        check("ackcnt_5", rd, 8'h05);

        // 256 more ack/reti rounds: ACK_COUNT saturates at 255
        wr(8'h00, 8'h01);
        src_flag = 8'h01;
        for (int n = 0; n < 256; n++) begin
            step();
            check("loop_irq", {7'd0, irq}, 8'h01);
            pulse_ack();
            pulse_reti();
        end
        src_flag = 8'h00;
        rdreg(8'h04, rd);
        check("ackcnt_sat", rd, 8'hFF);
        wr(8'h04, 8'hAA);
        rdreg(8'h04, rd);
        check("ackcnt_clr", rd, 8'h00);
        rdreg(8'h00, rd);
        check("enable_rd", rd, 8'h01);
        rdreg(8'h07, rd);
        check("unmapped_rd", rd, 8'h00);

        // Reset while in REQ abandons the request
        src_flag = 8'h01;
        step();
        check("pre_rst_irq", {7'd0, irq}, 8'h01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_irq", {7'd0, irq}, 8'h00);
        check("mid_rst_vec", {5'd0, irq_vector}, 8'h00);
        check("mid_rst_clr", src_clr, 8'h00);
        pulse_ack();
        check("post_rst_ack_clr", src_clr, 8'h00);
        check("post_rst_irq", {7'd0, irq}, 8'h00);
        rdreg(8'h00, rd);
        check("post_rst_enable", rd, 8'h00);
        rdreg(8'h03, rd);
        check("post_rst_control", rd, 8'h00);
        rdreg(8'h04, rd);
        check("post_rst_ackcnt", rd, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
